// File: rtl/led_scan_controller.sv
// rtl/led_scan_controller.sv - column scan for the Conway LED array with a one-deep frame buffer
module led_scan_controller #(
    parameter int N             = 5,
    parameter int TICKS_PER_COL = 12000,
    parameter int BLANK_TICKS   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*N-1:0]       cells_in,
    input  logic                 cells_valid,
    output logic                 cells_ready,
    output logic                 ena,
    output logic [$clog2(N):0]   x,
    output logic [N*N-1:0]       cells,
    output logic                 frame_done
);

    localparam int MAX_TICKS = (TICKS_PER_COL > BLANK_TICKS) ? TICKS_PER_COL : BLANK_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);
    localparam int XW        = $clog2(N) + 1;

    localparam logic [CW-1:0] T_LAST = CW'(TICKS_PER_COL - 1);
    localparam logic [CW-1:0] B_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [XW-1:0] X_LAST = XW'(N - 1);

    if (N < 1 || N > 8 || TICKS_PER_COL < 1 || BLANK_TICKS < 1) begin : g_bad_params
        initial $error("led_scan_controller: illegal parameters N=%0d TICKS_PER_COL=%0d BLANK_TICKS=%0d",
                       N, TICKS_PER_COL, BLANK_TICKS);
    end

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            col_end;
    logic            last_col;
    logic            xfer;
    logic            swap;
    logic [N*N-1:0]  shadow;
    logic            pending;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= BLANK;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        col_end    = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == B_LAST) begin
                    state_next = ON;
                    cnt_next   = '0;
                end
            end
            ON: begin
                if (cnt == T_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    col_end    = 1'b1;
                end
            end
            default: begin
                state_next = BLANK;
                cnt_next   = '0;
            end
        endcase
    end

    assign last_col    = (x == X_LAST);
    assign cells_ready = ~pending;
    assign xfer        = cells_valid && !pending;
    // Transfer requires pending=0 and swap requires pending=1, so they never collide.
    assign swap        = col_end && last_col && pending;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ena        <= 1'b0;
            x          <= '0;
            frame_done <= 1'b0;
            cells      <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
        end else begin
            ena        <= (state_next == ON);
            frame_done <= col_end && last_col;
            if (col_end) begin
                x <= last_col ? '0 : x + 1'b1;
            end
            if (xfer) begin
                shadow  <= cells_in;
                pending <= 1'b1;
            end else if (swap) begin
                cells   <= shadow;
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_scan_controller.sv
// tb/tb_led_scan_controller.sv - directed bench for led_scan_controller (5x5/4/2 and 1x1/1/1)
module tb_led_scan_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] cells_in;
    logic        cells_valid;
    logic        cells_ready;
    logic        ena;
    logic [3:0]  x;
    logic [24:0] cells;
    logic        frame_done;

    logic [0:0]  cells_in1;
    logic        cells_valid1;
    logic        cells_ready1;
    logic        ena1;
    logic [0:0]  x1;
    logic [0:0]  cells1;
    logic        frame_done1;

    int          vectors = 0;
    int          miscompares = 0;
    int          k = 0;
    logic [24:0] q[$];

    localparam logic [24:0] F0 = 25'h1F_FFFF;
    localparam logic [24:0] FA = 25'h0A5_A5A5;
    localparam logic [24:0] FB = 25'h15A_5A5A;
    localparam logic [24:0] FC = 25'h123_4567;
    localparam logic [24:0] FD = 25'h0F0_F0F0;

    always #5 clk = ~clk;

    led_scan_controller #(.N(5), .TICKS_PER_COL(4), .BLANK_TICKS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cells_in    (cells_in),
        .cells_valid (cells_valid),
        .cells_ready (cells_ready),
        .ena         (ena),
        .x           (x),
        .cells       (cells),
        .frame_done  (frame_done)
    );

    led_scan_controller #(.N(1), .TICKS_PER_COL(1), .BLANK_TICKS(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .cells_in    (cells_in1),
        .cells_valid (cells_valid1),
        .cells_ready (cells_ready1),
        .ena         (ena1),
        .x           (x1),
        .cells       (cells1),
        .frame_done  (frame_done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    // Column period 6 (2 blank + 4 on), frame period 30; the 1x1 instance alternates every cycle.
    task automatic cyc();
        bit xfer;
        xfer = cells_valid && cells_ready;
        @(posedge clk);
        #1;
        k++;
        if (xfer && q.size() > 0) void'(q.pop_front());
        if (q.size() > 0) begin
            cells_valid = 1'b1;
            cells_in    = q[0];
        end else begin
            cells_valid = 1'b0;
            cells_in    = 25'($urandom);
        end
        check("ena", 32'(ena), 32'((k % 6) >= 2));
        check("x", 32'(x), 32'((k / 6) % 5));
        check("frame_done", 32'(frame_done), 32'(k > 0 && (k % 30) == 0));
        check("ena_n1", 32'(ena1), 32'(k % 2));
        check("x_n1", 32'(x1), 32'd0);
        check("frame_done_n1", 32'(frame_done1), 32'(k > 0 && (k % 2) == 0));
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        q.delete();
        cells_valid = 1'b0;
        @(posedge clk);
        #1;
        k = 0;
        check("rst_ena", 32'(ena), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_cells", 32'(cells), 32'd0);
        check("rst_ready", 32'(cells_ready), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_cells_n1", 32'(cells1), 32'd0);
        check("rst_ena_n1", 32'(ena1), 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        rst          = 1'b0;
        cells_in     = '0;
        cells_valid  = 1'b0;
        cells_in1    = '0;
        cells_valid1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        repeat (3) cyc();
        q.push_back(F0);
        cells_valid = 1'b1;
        cells_in    = F0;
        cyc();
        check("ready_drop", 32'(cells_ready), 32'd0);
        repeat (25) cyc();
        check("cells_before_swap", 32'(cells), 32'd0);

        q.push_back(FA);
        q.push_back(FB);
        q.push_back(FC);
        cells_valid = 1'b1;
        cells_in    = FA;
        cyc();
        check("cells_first_swap", 32'(cells), 32'(F0));
        check("ready_after_swap", 32'(cells_ready), 32'd1);
        cyc();
        check("ready_accept_late", 32'(cells_ready), 32'd0);
        repeat (28) cyc();
        check("cells_hold_f0", 32'(cells), 32'(F0));
        cyc();
        check("cells_a", 32'(cells), 32'(FA));
        check("ready_at_60", 32'(cells_ready), 32'd1);
        repeat (29) cyc();
        check("cells_hold_a", 32'(cells), 32'(FA));
        cyc();
        check("cells_b", 32'(cells), 32'(FB));
        repeat (30) cyc();
        check("cells_c", 32'(cells), 32'(FC));
        repeat (30) cyc();
        check("cells_redisplay_c", 32'(cells), 32'(FC));
        check("ready_idle", 32'(cells_ready), 32'd1);

        q.push_back(FD);
        cells_valid = 1'b1;
        cells_in    = FD;
        cyc();
        check("ready_d_pending", 32'(cells_ready), 32'd0);
        repeat (9) cyc();
        check("ena_mid_column", 32'(ena), 32'd1);
        do_reset();

        repeat (30) cyc();
        check("d_discarded", 32'(cells), 32'd0);
        check("ready_after_rst", 32'(cells_ready), 32'd1);
        repeat (5) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
